// File: rtl/cmd_pkg.sv
// cmd_pkg: command encodings and ALU state type shared by cmd_alu and the stimulus generator.
package cmd_pkg;

   localparam int unsigned CMD_W = 3;

   typedef enum logic [CMD_W-1:0] {
      RST  = 3'd0,
      INIT = 3'd1,
      ADD  = 3'd2,
      SUB  = 3'd3,
      MULT = 3'd4,
      DIV  = 3'd5,
      REM  = 3'd6,
      HLT  = 3'd7
   } cmd_t;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv,
      StHalt
   } alu_state_t;

   // True for the two commands served by the divider.
   function automatic logic is_div_cmd(input cmd_t c);
      return (c == DIV) || (c == REM);
   endfunction

endpackage

// File: rtl/cmd_alu_div.sv
// cmd_alu_div: W-step unsigned restoring divider. Loads on start, then performs one step per
// clock. done is high during the cycle whose edge applies the final step; quot/rem present the
// value that step produces, so the parent captures the finished result on that same edge.
module cmd_alu_div #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quot,
   output logic [W-1:0] rem,
   output logic         done
);

   localparam int unsigned CntW = $clog2(W);

   logic            busy_q;
   logic [CntW-1:0] cnt_q;
   logic [W-1:0]    quot_q;
   logic [W-1:0]    rem_q;
   logic [W-1:0]    dsr_q;
   logic [W:0]      trial;
   logic            fits;

   // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
   always_comb begin
      trial = {rem_q, quot_q[W-1]};
      fits  = (trial >= {1'b0, dsr_q});
      // When fits, trial - divisor < 2^W, so a W-bit subtraction is exact.
      rem   = fits ? (trial[W-1:0] - dsr_q) : trial[W-1:0];
      quot  = {quot_q[W-2:0], fits};
      done  = busy_q && (cnt_q == CntW'(W - 1));
   end

   // Iteration state; a new start overrides any step in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         dsr_q  <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         quot_q <= dividend;
         rem_q  <= '0;
         dsr_q  <= divisor;
      end else if (busy_q) begin
         quot_q <= quot;
         rem_q  <= rem;
         cnt_q  <= cnt_q + CntW'(1);
         if (done) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cmd_alu.sv
// cmd_alu: command-execution unit. Accepts one command per rdy_i pulse while idle and reports
// completion with a one-cycle done_o tagged by done_cmd_o.
// Define CMD_ALU_FAST_MULT_EN to replace the W-cycle shift-add MULT with a single-cycle
// combinational multiplier.
module cmd_alu
   import cmd_pkg::*;
#(
   parameter int unsigned W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy_i,
   input  logic [CMD_W-1:0] cmd_i,
   input  logic [W-1:0]     opd1_i,
   input  logic [W-1:0]     opd2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CMD_W-1:0] done_cmd_o,
   output logic [W-1:0]     result_o,
   output logic             err_o,
   output logic             ovr_o
);

   localparam int unsigned CntW = $clog2(W);

   cmd_t            cmd_in;
   alu_state_t      state_q;
   logic            busy_q;
   logic            done_q;
   cmd_t            done_cmd_q;
   cmd_t            op_q;
   logic [W-1:0]    result_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            err_q;
   logic            ovr_q;
   logic            pend_q;   // captured op completes on the next edge
   logic [CntW-1:0] cnt_q;
   logic            iter_cmd;
   logic            div_start;
   logic            div_done;
   logic [W-1:0]    div_quot;
   logic [W-1:0]    div_rem;
   logic [W-1:0]    exec_res;
`ifndef CMD_ALU_FAST_MULT_EN
   logic [W-1:0]    acc_q;
   logic [W-1:0]    acc_step;
`endif

   assign cmd_in = cmd_t'(cmd_i);

   // Commands that iterate rather than completing on the next edge.
   always_comb begin
      iter_cmd = 1'b0;
      case (cmd_in)
`ifndef CMD_ALU_FAST_MULT_EN
         MULT:     iter_cmd = 1'b1;
`endif
         DIV, REM: iter_cmd = (opd2_i != '0);
         default:  iter_cmd = 1'b0;
      endcase
   end

   assign div_start = rdy_i && (state_q == StIdle) && is_div_cmd(cmd_in) && iter_cmd;

`ifndef CMD_ALU_FAST_MULT_EN
   // One shift-add step; the 64th step is folded into the completing edge.
   assign acc_step = b_q[0] ? (acc_q + a_q) : acc_q;
`endif

   // Result for an op completing via pend_q, from operands captured at acceptance.
   always_comb begin
      exec_res = result_q;
      case (op_q)
         RST:     exec_res = '0;
         INIT:    exec_res = a_q;
         ADD:     exec_res = a_q + b_q;
         SUB:     exec_res = a_q - b_q;
`ifdef CMD_ALU_FAST_MULT_EN
         MULT:    exec_res = a_q * b_q;
`else
         MULT:    exec_res = acc_step;
`endif
         DIV:     exec_res = '1;     // only divide-by-zero completes this way
         REM:     exec_res = a_q;
         default: exec_res = result_q;
      endcase
   end

   cmd_alu_div #(
      .W(W)
   ) u_div (
      .clk     (clk),
      .rst     (rst),
      .start   (div_start),
      .dividend(opd1_i),
      .divisor (opd2_i),
      .quot    (div_quot),
      .rem     (div_rem),
      .done    (div_done)
   );

   // Control FSM, operand capture, iteration and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         done_cmd_q <= RST;
         op_q       <= RST;
         result_q   <= '0;
         a_q        <= '0;
         b_q        <= '0;
         err_q      <= 1'b0;
         ovr_q      <= 1'b0;
         pend_q     <= 1'b0;
         cnt_q      <= '0;
`ifndef CMD_ALU_FAST_MULT_EN
         acc_q      <= '0;
`endif
      end else begin
         // busy_o trails the state by one edge.
         busy_q <= (state_q != StIdle);
         done_q <= 1'b0;
         pend_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (rdy_i) begin
                  op_q   <= cmd_in;
                  a_q    <= opd1_i;
                  b_q    <= opd2_i;
                  cnt_q  <= '0;
                  pend_q <= !iter_cmd;
`ifndef CMD_ALU_FAST_MULT_EN
                  acc_q  <= '0;
`endif
                  if (cmd_in == HLT) begin
                     state_q <= StHalt;
                  end else if (iter_cmd) begin
                     state_q <= (cmd_in == MULT) ? StMul : StDiv;
                  end
               end
            end
`ifndef CMD_ALU_FAST_MULT_EN
            StMul: begin
               if (rdy_i) begin
                  ovr_q <= 1'b1;
               end
               acc_q <= acc_step;
               a_q   <= a_q << 1;
               b_q   <= b_q >> 1;
               cnt_q <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(W - 2)) begin
                  state_q <= StIdle;
                  pend_q  <= 1'b1;
               end
            end
`endif
            StDiv: begin
               if (rdy_i) begin
                  ovr_q <= 1'b1;
               end
               cnt_q <= cnt_q + CntW'(1);
               // Idle one edge early so a command can be accepted on the completing edge.
               if (cnt_q == CntW'(W - 2)) begin
                  state_q <= StIdle;
               end
            end
            StHalt: begin
               if (rdy_i && (cmd_in == RST)) begin
                  op_q    <= RST;
                  pend_q  <= 1'b1;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         if (pend_q) begin
            result_q   <= exec_res;
            done_q     <= 1'b1;
            done_cmd_q <= op_q;
            case (op_q)
               RST, INIT: begin
                  err_q <= 1'b0;
                  ovr_q <= 1'b0;
               end
               DIV, REM:  err_q <= 1'b1;
               default:   ;
            endcase
         end else if (div_done) begin
            result_q   <= (op_q == DIV) ? div_quot : div_rem;
            done_q     <= 1'b1;
            done_cmd_q <= op_q;
         end
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign done_cmd_o = done_cmd_q;
   assign result_o   = result_q;
   assign err_o      = err_q;
   assign ovr_o      = ovr_q;

endmodule
